mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_if.sv | 25 ++
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mul_div_if.sv
// Request/response bundle between the core pipeline and the iterative RV32M unit.
// The core drives requests and flush; the unit returns stall, result and writeback.
interface mul_div_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we_out;

    modport master (
        output start, op, rs1_val, rs2_val, rd_addr, flush,
        input  busy, done, result, rd_out, we_out
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_addr, flush,
        output busy, done, result, rd_out, we_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// 32 iterations on operand magnitudes, sign fix-up folded into the last iteration.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    mul_div_if.slave bus
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST    = 5'd31;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt;
    logic [2:0]        op_r;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   hi, lo, mcand;
    logic [4:0]        rd_pend, rd_r;
    logic [XLEN-1:0]   result_r;

    logic              accept, div_zero, ovf, bypass;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, bypass_res;
    logic [XLEN:0]     mul_sum, div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo, final_res;
    logic [2*XLEN-1:0] prod;

    assign accept = bus.start & ~bus.flush & (state != CALC);

    // Operand decode on the raw request; only meaningful on the accepting edge.
    always_comb begin
        a_signed = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        b_signed = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
        a_neg    = a_signed & bus.rs1_val[XLEN-1];
        b_neg    = b_signed & bus.rs2_val[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
        div_zero = bus.op[2] & (bus.rs2_val == '0);
        ovf      = bus.op[2] & ~bus.op[0] & (bus.rs1_val == MIN_INT) & (bus.rs2_val == '1);
        bypass   = div_zero | ovf;
        if (div_zero)
            bypass_res = bus.op[1] ? bus.rs1_val : '1;
        else
            bypass_res = bus.op[1] ? '0 : MIN_INT;
    end

    // One iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_sh  = {hi, lo[XLEN-1]};
        div_ge  = div_sh >= {1'b0, mcand};
        if (op_r[2]) begin
            step_hi = div_ge ? (div_sh[XLEN-1:0] - mcand) : div_sh[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod = {step_hi, step_lo};
        if (neg_q)
            prod = -prod;
        case (op_r)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = neg_q ? -step_lo : step_lo;
            default:                final_res = neg_r ? -step_hi : step_hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (accept)
                    state_nxt = bypass ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (cnt == LAST)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_r     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            rd_pend  <= '0;
            rd_r     <= '0;
            result_r <= '0;
        end else if (accept) begin
            op_r    <= bus.op;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            hi      <= '0;
            lo      <= bus.op[2] ? a_mag : b_mag;
            mcand   <= bus.op[2] ? b_mag : a_mag;
            rd_pend <= bus.rd_addr;
            cnt     <= '0;
            if (bypass) begin
                result_r <= bypass_res;
                rd_r     <= bus.rd_addr;
            end
        end else if (state == CALC) begin
            if (bus.flush) begin
                cnt <= '0;
            end else begin
                hi  <= step_hi;
                lo  <= step_lo;
                cnt <= cnt + 5'd1;
                // Result and destination only move on entry to DONE so they stay stable between dones.
                if (cnt == LAST) begin
                    result_r <= final_res;
                    rd_r     <= rd_pend;
                end
            end
        end
    end

    assign bus.busy   = (state == CALC);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.rd_out = rd_r;
    assign bus.we_out = (state == DONE) && (rd_r != 5'd0);

endmodule
